// File: rtl/cmul_seq.sv
// rtl/cmul_seq.sv - four-cycle signed complex multiplier sharing one unsigned WxW product unit
module cmul_seq #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   ar,
   input  logic [W-1:0]   ai,
   input  logic [W-1:0]   br,
   input  logic [W-1:0]   bi,
   output logic           ready,
   output logic           valid,
   output logic [2*W:0]   pr,
   output logic [2*W:0]   pi
);

   localparam int PW = 2 * W + 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_M0   = 3'd1,
      S_M1   = 3'd2,
      S_M2   = 3'd3,
      S_M3   = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [W-1:0]    r_ar, r_ai, r_br, r_bi;
   logic [PW-1:0]   r_acc_r, r_acc_i;
   logic [PW-1:0]   r_pr, r_pi;

   logic [W-1:0]    w_x, w_y;
   logic [W-1:0]    w_mag_x, w_mag_y;
   logic [2*W-1:0]  w_prod;
   logic [PW-1:0]   w_prod_ext;
   logic [PW-1:0]   w_term;
   logic            w_neg;

   // |-2^(W-1)| = 2^(W-1) still fits the W-bit unsigned operand.
   function automatic logic [W-1:0] f_mag(input logic [W-1:0] v);
      f_mag = v[W-1] ? (~v + W'(1)) : v;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = start ? S_M0 : S_IDLE;
         S_M0:    w_next = S_M1;
         S_M1:    w_next = S_M2;
         S_M2:    w_next = S_M3;
         S_M3:    w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      ready = (r_state == S_IDLE);
      valid = (r_state == S_DONE);
   end

   always_comb begin
      w_x = r_ar;
      w_y = r_br;
      case (r_state)
         S_M1:    begin w_x = r_ai; w_y = r_bi; end
         S_M2:    begin w_x = r_ar; w_y = r_bi; end
         S_M3:    begin w_x = r_ai; w_y = r_br; end
         default: begin w_x = r_ar; w_y = r_br; end
      endcase
   end

   // Shared unsigned product unit; sign is reapplied afterwards.
   assign w_mag_x    = f_mag(w_x);
   assign w_mag_y    = f_mag(w_y);
   assign w_prod     = {{W{1'b0}}, w_mag_x} * {{W{1'b0}}, w_mag_y};
   assign w_prod_ext = {1'b0, w_prod};
   assign w_neg      = w_x[W-1] ^ w_y[W-1];
   assign w_term     = w_neg ? (PW'(0) - w_prod_ext) : w_prod_ext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ar    <= '0;
         r_ai    <= '0;
         r_br    <= '0;
         r_bi    <= '0;
         r_acc_r <= '0;
         r_acc_i <= '0;
         r_pr    <= '0;
         r_pi    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_ar    <= ar;
                  r_ai    <= ai;
                  r_br    <= br;
                  r_bi    <= bi;
                  r_acc_r <= '0;
                  r_acc_i <= '0;
               end
            end
            S_M0: r_acc_r <= w_term;
            S_M1: r_acc_r <= r_acc_r - w_term;
            S_M2: r_acc_i <= w_term;
            S_M3: begin
               r_acc_i <= r_acc_i + w_term;
               r_pr    <= r_acc_r;
               r_pi    <= r_acc_i + w_term;
            end
            default: ;
         endcase
      end
   end

   assign pr = r_pr;
   assign pi = r_pi;

endmodule

// File: tb/tb_cmul_seq.sv
// tb/tb_cmul_seq.sv - self-checking bench for cmul_seq against a cycle-level reference model
module tb_cmul_seq;

   localparam int W = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 start = 1'b0;
   logic signed [W-1:0]  ar = '0, ai = '0, br = '0, bi = '0;
   logic                 ready, valid;
   logic signed [2*W:0]  pr, pi;

   int n_cmp  = 0;
   int n_fail = 0;
   logic chk_en = 1'b0;
   logic prev_valid = 1'b0;

   cmul_seq #(.W(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .ar    (ar),
      .ai    (ai),
      .br    (br),
      .bi    (bi),
      .ready (ready),
      .valid (valid),
      .pr    (pr),
      .pi    (pi)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an op accepted at edge A delivers at A+4 and frees the block for A+6.
   int m_cyc = 0;
   int m_acc = -100;
   int m_pr = 0, m_pi = 0, m_pend_pr = 0, m_pend_pi = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cyc     <= 0;
         m_acc     <= -100;
         m_pr      <= 0;
         m_pi      <= 0;
         m_pend_pr <= 0;
         m_pend_pi <= 0;
      end else begin
         m_cyc <= m_cyc + 1;
         if (start && (m_cyc + 1 >= m_acc + 6)) begin
            m_acc     <= m_cyc + 1;
            m_pend_pr <= int'(ar) * int'(br) - int'(ai) * int'(bi);
            m_pend_pi <= int'(ar) * int'(bi) + int'(ai) * int'(br);
         end
         if (m_cyc + 1 == m_acc + 4) begin
            m_pr <= m_pend_pr;
            m_pi <= m_pend_pi;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", int'(ready), int'(!(m_cyc >= m_acc && m_cyc <= m_acc + 4)));
         chk("valid", int'(valid), int'(m_cyc == m_acc + 4));
         chk("pr", int'(pr), m_pr);
         chk("pi", int'(pi), m_pi);
         chk("valid_twice", int'(valid && prev_valid), 0);
         chk("ready_and_valid", int'(ready && valid), 0);
      end
      prev_valid <= valid;
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ready) chk("wait_ready_timeout", 0, 1);
   endtask

   task automatic start_op(input int a, input int b, input int c, input int d);
      ar = W'(a); ai = W'(b); br = W'(c); bi = W'(d);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid(output int edges);
      edges = 0;
      do begin
         @(negedge clk);
         edges++;
      end while (!valid && edges < 20);
      if (!valid) chk("wait_valid_timeout", 0, 1);
   endtask

   task automatic op_check(input string name, input int a, input int b, input int c, input int d,
                           input int epr, input int epi);
      int e;
      wait_ready();
      start_op(a, b, c, d);
      wait_valid(e);
      chk({name, "_latency"}, e, 4);
      chk({name, "_pr"}, int'(pr), epr);
      chk({name, "_pi"}, int'(pi), epi);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e, nv;
      rst = 1'b1;
      @(posedge clk);
      #1 chk_en = 1'b1;
      chk("rst_ready", int'(ready), 1);
      chk("rst_valid", int'(valid), 0);
      chk("rst_pr", int'(pr), 0);
      chk("rst_pi", int'(pi), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      op_check("basic", 3, 2, 1, 4, -5, 14);
      @(negedge clk);
      chk("basic_ready_back", int'(ready), 1);

      op_check("ext_all_min", -8, -8, -8, -8, 0, 128);
      op_check("ext_mixed", -8, 7, -8, -8, 120, 8);

      // Busy drop: a start pulse during M1 must be ignored.
      wait_ready();
      start_op(1, 1, 1, 1);
      @(negedge clk);
      ar = 4'sd5; ai = -4'sd3; br = 4'sd2; bi = 4'sd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_valid(e);
      chk("drop_pr", int'(pr), 0);
      chk("drop_pi", int'(pi), 2);
      nv = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (valid) nv++;
      end
      chk("drop_no_second_valid", nv, 0);

      // Asynchronous reset during M2.
      wait_ready();
      start_op(3, 3, 3, 3);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_ready", int'(ready), 1);
      chk("arst_valid", int'(valid), 0);
      chk("arst_pr", int'(pr), 0);
      chk("arst_pi", int'(pi), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      nv = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (valid) nv++;
      end
      chk("arst_no_valid", nv, 0);
      op_check("after_rst", 2, -3, -4, 1, -5, 14);

      // Back-to-back with start held and operands changing every cycle.
      wait_ready();
      nv = 0;
      start = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         ar = W'($urandom); ai = W'($urandom); br = W'($urandom); bi = W'($urandom);
         @(negedge clk);
         if (valid) nv++;
         if (i == 59) chk("b2b_valids_60", nv, 10);
      end
      start = 1'b0;
      chk("random_valid_count", nv, 1000);
      repeat (8) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
